credit_step_sequencer: RTL and testbench
========================================

# credit_step_sequencer

Parametrised, clocked successor to the combinational credit/state/display path. It accumulates credit from coin pulses, consumes a fixed price per accepted advance request, and steps a wrapping sequence counter through `N_STEPS` states. It supports four operating modes: normal, free, hold and refund. The current step is shown on a 7-segment output, and an illegal advance is flagged. It sits between the board inputs (`ui_in`) and the display and status outputs (`uo_out`) in the top-level wrapper.

## Interface
Parameters:
- `CREDIT_W`, default 4: credit register and coin value width (2..8).
- `N_STEPS`, default 8: number of sequence steps (2..16). `STEP_W = $clog2(N_STEPS)`.
- `PRICE`, default 1: credit consumed per accepted advance (1..2^CREDIT_W-1).
- `SEG_ACTIVE_LOW`, default 0: 1 inverts all `seg` bits.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `coin_valid` in 1: one-cycle strobe; adds `coin_value` to credit.
- `coin_value` in CREDIT_W: coin amount; sampled only when `coin_valid`=1.
- `advance` in 1: level input; rising edge detected internally.
- `mode` in 2: 00 normal, 01 free, 10 hold, 11 refund.
- `credit` out CREDIT_W: current credit (registered).
- `has_credit` out 1: `credit >= PRICE` (combinational from register).
- `step` out STEP_W: current step (registered).
- `seg` out 7: hex glyph of `step`; bit order g,f,e,d,c,b,a = [6:0].
- `wrap` out 1: one-cycle pulse when step goes from N_STEPS-1 to 0.
- `deny` out 1: one-cycle pulse when an advance edge is rejected for insufficient credit.
- `overflow` out 1: sticky; set on credit saturation.
- `refund_valid` out 1: one-cycle strobe.
- `refund_amount` out CREDIT_W: credit returned; valid with `refund_valid`, 0 otherwise.

## Operation
- Edge detect:
  - `adv_q` <= `advance` every cycle, including during reset, so a level held through reset is not an edge.
  - `adv_edge = advance & ~adv_q`.
- Coin add: `sum = credit + coin_value`, computed at CREDIT_W+1 bits. If `sum > 2^CREDIT_W-1`, credit saturates to all-ones and `overflow` is set.
- Mode 00, normal: on `adv_edge`, legality is judged on the registered `credit` only, never including a same-cycle coin.
  - If `credit >= PRICE`: `step` increments and `credit_next = sat(credit - PRICE + coin)`.
  - Otherwise: `deny` pulses, `step` is held, and any same-cycle coin is still added.
- Mode 01, free: every `adv_edge` advances `step`; credit is untouched; coins are accepted.
- Mode 10, hold: `adv_edge` is ignored with no `deny`; coins are accepted.
- Mode 11, refund:
  - Each cycle with `credit != 0`: `refund_valid`=1, `refund_amount`=`credit`, credit cleared to 0 and `overflow` cleared.
  - Coins are discarded and `adv_edge` is ignored.
  - With credit already 0, no strobe is issued.
- Step wrap: step N_STEPS-1 advances to 0 and pulses `wrap` in the same cycle. `step` never exceeds N_STEPS-1.
- `seg`: combinational hex decode 0..F of `step`, zero-extended, XOR SEG_ACTIVE_LOW. Glyphs are standard, e.g. 0 = 0111111, 1 = 0000110.
- Mode changes take effect on the cycle they are sampled; there is no internal mode state.

## Timing
- Reset values while `rst`=1 at a clock edge: `credit`=0, `step`=0, `overflow`=0, `wrap`=0, `deny`=0, `refund_valid`=0, `refund_amount`=0. `has_credit`=0 follows.
- Latency:
  - A coin strobe at edge k is reflected in `credit` after edge k.
  - An `advance` low at edge k-1 and high at edge k updates `step`, `wrap`, `deny` and `credit` after edge k.
  - `seg` follows `step` combinationally.
- Pulses (`wrap`, `deny`, `refund_valid`) are registered and last exactly one cycle per event.
- A held `advance` produces one edge only. Back-to-back advances need `advance` low for at least one sampled cycle.
- Reset mid-refund or mid-advance: reset wins and all registers take their reset values at that edge.
- `coin_valid` with `coin_value`=0 is legal and has no effect.

## Test plan
- Reset with `advance` held high, then release reset -> `step`=0, `credit`=0, no step change until `advance` goes low then high.
- Defaults, mode 00: coin 3, then 3 advance edges -> `step` 1,2,3 and `credit` 2,1,0; a 4th edge -> `deny`=1 for one cycle, `step`=3.
- Coin 1 with `credit`=0 and `adv_edge` in the same cycle -> `deny` pulses, `credit`=1, `step` unchanged.
- `credit`=14, coin 5 -> `credit`=15, `overflow`=1; mode 11 -> `refund_valid` for one cycle with `refund_amount`=15, then `credit`=0 and `overflow`=0.
- Mode 01 with 8 advance edges from `step`=0 -> `step` returns to 0, `wrap` pulses exactly once, `credit` unchanged.
- N_STEPS=16, SEG_ACTIVE_LOW=1: step to 10 -> `seg` = ~7'b1110111 (glyph "A"); mode 10 with an advance edge -> no change, no `deny`.

Source files
------------

// File: rtl/credit_step_sequencer.sv
// Coin-credit accumulator driving a wrapping step counter with a 7-segment view of the step.
// Supports normal, free, hold and refund modes; denied advances and credit saturation are flagged.
module credit_step_sequencer #(
  parameter int CREDIT_W       = 4,
  parameter int N_STEPS        = 8,
  parameter int PRICE          = 1,
  parameter int SEG_ACTIVE_LOW = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       coin_valid,
  input  logic [CREDIT_W-1:0]        coin_value,
  input  logic                       advance,
  input  logic [1:0]                 mode,
  output logic [CREDIT_W-1:0]        credit,
  output logic                       has_credit,
  output logic [$clog2(N_STEPS)-1:0] step,
  output logic [6:0]                 seg,
  output logic                       wrap,
  output logic                       deny,
  output logic                       overflow,
  output logic                       refund_valid,
  output logic [CREDIT_W-1:0]        refund_amount
);

  localparam int STEP_W = $clog2(N_STEPS);
  localparam logic [CREDIT_W-1:0] PRICE_C   = CREDIT_W'(PRICE);
  localparam logic [STEP_W-1:0]   LAST_STEP = STEP_W'(N_STEPS - 1);

  typedef enum logic [1:0] {
    MODE_NORMAL = 2'b00,
    MODE_FREE   = 2'b01,
    MODE_HOLD   = 2'b10,
    MODE_REFUND = 2'b11
  } mode_t;

  mode_t               op;
  logic                adv_q;
  logic                adv_edge;
  logic                pay;
  logic                step_go;
  logic                refund_go;
  logic [CREDIT_W-1:0] coin_add;
  logic [CREDIT_W:0]   base;
  logic [CREDIT_W:0]   sum;
  logic [6:0]          glyph;

  assign op         = mode_t'(mode);
  assign has_credit = (credit >= PRICE_C);

  // Legality uses the registered credit only; the price comes off before the coin is added.
  always_comb begin
    adv_edge  = advance & ~adv_q;
    coin_add  = coin_valid ? coin_value : '0;
    pay       = 1'b0;
    step_go   = 1'b0;
    refund_go = 1'b0;
    case (op)
      MODE_NORMAL: begin
        pay     = adv_edge && (credit >= PRICE_C);
        step_go = pay;
      end
      MODE_FREE:   step_go = adv_edge;
      MODE_HOLD:   step_go = 1'b0;
      MODE_REFUND: begin
        refund_go = (credit != '0);
        coin_add  = '0;
      end
      default:     step_go = 1'b0;
    endcase
    base = pay ? {1'b0, credit - PRICE_C} : {1'b0, credit};
    sum  = base + {1'b0, coin_add};
  end

  always_ff @(posedge clk) begin
    adv_q <= advance;
    if (rst) begin
      credit        <= '0;
      step          <= '0;
      overflow      <= 1'b0;
      wrap          <= 1'b0;
      deny          <= 1'b0;
      refund_valid  <= 1'b0;
      refund_amount <= '0;
    end else begin
      wrap          <= 1'b0;
      deny          <= (op == MODE_NORMAL) && adv_edge && !pay;
      refund_valid  <= refund_go;
      refund_amount <= refund_go ? credit : '0;
      if (refund_go) begin
        credit   <= '0;
        overflow <= 1'b0;
      end else if (sum[CREDIT_W]) begin
        credit   <= '1;
        overflow <= 1'b1;
      end else begin
        credit <= sum[CREDIT_W-1:0];
      end
      if (step_go) begin
        if (step == LAST_STEP) begin
          step <= '0;
          wrap <= 1'b1;
        end else begin
          step <= step + STEP_W'(1);
        end
      end
    end
  end

  always_comb begin
    case (4'(step))
      4'h0: glyph = 7'b0111111;
      4'h1: glyph = 7'b0000110;
      4'h2: glyph = 7'b1011011;
      4'h3: glyph = 7'b1001111;
      4'h4: glyph = 7'b1100110;
      4'h5: glyph = 7'b1101101;
      4'h6: glyph = 7'b1111101;
      4'h7: glyph = 7'b0000111;
      4'h8: glyph = 7'b1111111;
      4'h9: glyph = 7'b1101111;
      4'hA: glyph = 7'b1110111;
      4'hB: glyph = 7'b1111100;
      4'hC: glyph = 7'b0111001;
      4'hD: glyph = 7'b1011110;
      4'hE: glyph = 7'b1111001;
      default: glyph = 7'b1110001;
    endcase
  end

  assign seg = (SEG_ACTIVE_LOW != 0) ? ~glyph : glyph;

endmodule

// File: tb/tb_credit_step_sequencer.sv
// Bench for credit_step_sequencer: directed scenarios plus a randomized run against a behavioural model.
module tb_credit_step_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       coin_valid = 1'b0;
  logic [3:0] coin_value = '0;
  logic       advance = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [3:0] credit;
  logic       has_credit;
  logic [2:0] step;
  logic [6:0] seg;
  logic       wrap, deny, overflow, refund_valid;
  logic [3:0] refund_amount;

  logic       b_rst = 1'b1;
  logic       b_coin_valid = 1'b0;
  logic [3:0] b_coin_value = '0;
  logic       b_advance = 1'b0;
  logic [1:0] b_mode = 2'b00;
  logic [3:0] b_credit;
  logic       b_has_credit;
  logic [3:0] b_step;
  logic [6:0] b_seg;
  logic       b_wrap, b_deny, b_overflow, b_refund_valid;
  logic [3:0] b_refund_amount;

  int errors = 0;
  int checks = 0;

  int m_credit, m_step, m_ra;
  bit m_ovf, m_wrap, m_deny, m_rv, m_adv_q;

  always #5 clk = ~clk;

  credit_step_sequencer u0 (
    .clk(clk), .rst(rst), .coin_valid(coin_valid), .coin_value(coin_value),
    .advance(advance), .mode(mode), .credit(credit), .has_credit(has_credit),
    .step(step), .seg(seg), .wrap(wrap), .deny(deny), .overflow(overflow),
    .refund_valid(refund_valid), .refund_amount(refund_amount)
  );

  credit_step_sequencer #(.N_STEPS(16), .SEG_ACTIVE_LOW(1)) u1 (
    .clk(clk), .rst(b_rst), .coin_valid(b_coin_valid), .coin_value(b_coin_value),
    .advance(b_advance), .mode(b_mode), .credit(b_credit), .has_credit(b_has_credit),
    .step(b_step), .seg(b_seg), .wrap(b_wrap), .deny(b_deny), .overflow(b_overflow),
    .refund_valid(b_refund_valid), .refund_amount(b_refund_amount)
  );

  function automatic logic [6:0] exp_glyph(input int v);
    case (v)
      0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
      4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
      8: return 7'h7F;  9: return 7'h6F;  10: return 7'h77; 11: return 7'h7C;
      12: return 7'h39; 13: return 7'h5E; 14: return 7'h79; default: return 7'h71;
    endcase
  endfunction

  // Advance one clock for u0's model (8 steps, price 1, 4-bit credit), then settle past the edge.
  task automatic tick();
    bit e;
    int coin;
    e    = advance && !m_adv_q;
    coin = coin_valid ? int'(coin_value) : 0;
    if (rst) begin
      m_credit = 0; m_step = 0; m_ovf = 0; m_wrap = 0; m_deny = 0; m_rv = 0; m_ra = 0;
    end else begin
      m_wrap = 0; m_deny = 0; m_rv = 0; m_ra = 0;
      if (mode == 2'b11) begin
        if (m_credit != 0) begin
          m_rv = 1; m_ra = m_credit; m_credit = 0; m_ovf = 0;
        end
      end else begin
        if (e && mode == 2'b00) begin
          if (m_credit >= 1) begin
            m_credit -= 1;
            m_step = (m_step + 1) % 8;
            m_wrap = (m_step == 0);
          end else begin
            m_deny = 1;
          end
        end else if (e && mode == 2'b01) begin
          m_step = (m_step + 1) % 8;
          m_wrap = (m_step == 0);
        end
        m_credit += coin;
        if (m_credit > 15) begin
          m_credit = 15; m_ovf = 1;
        end
      end
    end
    m_adv_q = advance;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1; advance = 1; mode = 2'b01;
    tick(); tick();
    checks++;
    if (credit !== 4'd0 || step !== 3'd0 || has_credit !== 1'b0) begin
      errors++; $display("FAIL reset_state: credit=%0d step=%0d has_credit=%b want 0 0 0", credit, step, has_credit);
    end
    checks++;
    if ({wrap, deny, overflow, refund_valid} !== 4'b0 || refund_amount !== 4'd0) begin
      errors++; $display("FAIL reset_flags: w/d/o/rv=%b ra=%0d want 0000 0", {wrap, deny, overflow, refund_valid}, refund_amount);
    end
    rst = 0;
    tick(); tick();
    checks++;
    if (step !== 3'd0) begin
      errors++; $display("FAIL reset_held_advance: step=%0d want 0", step);
    end
    advance = 0; tick();
    advance = 1; tick();
    checks++;
    if (step !== 3'd1) begin
      errors++; $display("FAIL reset_first_edge: step=%0d want 1", step);
    end
    rst = 1; tick();
    rst = 0; advance = 0; mode = 2'b00; tick();
  endtask

  task automatic test_normal();
    coin_valid = 1; coin_value = 4'd3; tick();
    coin_valid = 0;
    checks++;
    if (credit !== 4'd3 || has_credit !== 1'b1) begin
      errors++; $display("FAIL normal_coin: credit=%0d has_credit=%b want 3 1", credit, has_credit);
    end
    for (int i = 1; i <= 3; i++) begin
      advance = 1; tick();
      checks++;
      if (step !== 3'(i) || credit !== 4'(3 - i) || deny !== 1'b0) begin
        errors++; $display("FAIL normal_adv%0d: step=%0d credit=%0d deny=%b want %0d %0d 0", i, step, credit, deny, i, 3 - i);
      end
      advance = 0; tick();
    end
    advance = 1; tick();
    checks++;
    if (deny !== 1'b1 || step !== 3'd3 || credit !== 4'd0) begin
      errors++; $display("FAIL normal_deny: deny=%b step=%0d credit=%0d want 1 3 0", deny, step, credit);
    end
    advance = 0; tick();
    checks++;
    if (deny !== 1'b0) begin
      errors++; $display("FAIL normal_deny_width: deny=%b want 0", deny);
    end
  endtask

  task automatic test_coin_same_cycle();
    coin_valid = 1; coin_value = 4'd1; advance = 1; tick();
    coin_valid = 0;
    checks++;
    if (deny !== 1'b1 || credit !== 4'd1 || step !== 3'd3) begin
      errors++; $display("FAIL same_cycle_coin: deny=%b credit=%0d step=%0d want 1 1 3", deny, credit, step);
    end
    advance = 0; tick();
  endtask

  task automatic test_overflow_refund();
    coin_valid = 1; coin_value = 4'd13; tick();
    coin_value = 4'd5; tick();
    coin_valid = 0;
    checks++;
    if (credit !== 4'd15 || overflow !== 1'b1) begin
      errors++; $display("FAIL saturate: credit=%0d overflow=%b want 15 1", credit, overflow);
    end
    mode = 2'b11; tick();
    checks++;
    if (refund_valid !== 1'b1 || refund_amount !== 4'd15 || credit !== 4'd0 || overflow !== 1'b0) begin
      errors++; $display("FAIL refund: rv=%b ra=%0d credit=%0d ovf=%b want 1 15 0 0", refund_valid, refund_amount, credit, overflow);
    end
    tick();
    checks++;
    if (refund_valid !== 1'b0 || refund_amount !== 4'd0) begin
      errors++; $display("FAIL refund_once: rv=%b ra=%0d want 0 0", refund_valid, refund_amount);
    end
    mode = 2'b00;
  endtask

  task automatic test_free_wrap();
    int wraps = 0;
    rst = 1; tick();
    rst = 0; coin_valid = 1; coin_value = 4'd2; tick();
    coin_valid = 0; mode = 2'b01;
    for (int i = 0; i < 8; i++) begin
      advance = 1; tick();
      wraps += int'(wrap);
      checks++;
      if (step !== 3'((i + 1) % 8)) begin
        errors++; $display("FAIL free_step%0d: step=%0d want %0d", i, step, (i + 1) % 8);
      end
      advance = 0; tick();
      wraps += int'(wrap);
    end
    checks++;
    if (wraps != 1 || credit !== 4'd2) begin
      errors++; $display("FAIL free_wrap: wraps=%0d credit=%0d want 1 2", wraps, credit);
    end
    mode = 2'b00;
  endtask

  task automatic test_param_variant();
    b_rst = 1; tick();
    b_rst = 0;
    checks++;
    if (b_seg !== ~7'h3F || b_step !== 4'd0) begin
      errors++; $display("FAIL param_reset_seg: seg=%b step=%0d want %b 0", b_seg, b_step, ~7'h3F);
    end
    b_mode = 2'b01;
    for (int i = 0; i < 10; i++) begin
      b_advance = 1; tick();
      b_advance = 0; tick();
    end
    checks++;
    if (b_step !== 4'd10 || b_seg !== ~7'b1110111) begin
      errors++; $display("FAIL param_seg_A: step=%0d seg=%b want 10 %b", b_step, b_seg, ~7'b1110111);
    end
    b_mode = 2'b10; b_advance = 1; tick();
    checks++;
    if (b_step !== 4'd10 || b_deny !== 1'b0 || b_credit !== 4'd0) begin
      errors++; $display("FAIL param_hold: step=%0d deny=%b credit=%0d want 10 0 0", b_step, b_deny, b_credit);
    end
    b_advance = 0; tick();
  endtask

  task automatic test_random();
    rst = 1; tick();
    rst = 0;
    for (int n = 0; n < 600; n++) begin
      rst        = ($urandom_range(0, 59) == 0);
      coin_valid = ($urandom_range(0, 9) < 4);
      coin_value = 4'($urandom_range(0, 15));
      advance    = $urandom_range(0, 1) == 1;
      mode       = 2'($urandom_range(0, 3));
      tick();
      checks++;
      if (credit !== 4'(m_credit) || has_credit !== (m_credit >= 1)) begin
        errors++; $display("FAIL rand_credit[%0d]: credit=%0d has=%b want %0d %b", n, credit, has_credit, m_credit, m_credit >= 1);
      end
      checks++;
      if (step !== 3'(m_step) || seg !== exp_glyph(m_step)) begin
        errors++; $display("FAIL rand_step[%0d]: step=%0d seg=%b want %0d %b", n, step, seg, m_step, exp_glyph(m_step));
      end
      checks++;
      if ({wrap, deny, overflow} !== {m_wrap, m_deny, m_ovf}) begin
        errors++; $display("FAIL rand_flags[%0d]: w/d/o=%b want %b", n, {wrap, deny, overflow}, {m_wrap, m_deny, m_ovf});
      end
      checks++;
      if (refund_valid !== m_rv || refund_amount !== 4'(m_ra)) begin
        errors++; $display("FAIL rand_refund[%0d]: rv=%b ra=%0d want %b %0d", n, refund_valid, refund_amount, m_rv, m_ra);
      end
    end
    rst = 0;
  endtask

  initial begin
    m_adv_q = 0;
    test_reset();
    test_normal();
    test_coin_same_cycle();
    test_overflow_refund();
    test_free_wrap();
    test_param_variant();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
